mc_controller: RTL and testbench

Multicycle control unit for the RISC-V datapath in `cpu`. It consumes the opcode and function fields from the instruction register and the ALU `zero` flag. It sequences Fetch/Decode/Execute/Memory/Writeback and drives every datapath select and enable signal. It is the controlling end of the `cpu` control interface and replaces the tie-offs currently on those nets.

---
 rtl/mc_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_mc_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Brief    : Multicycle RISC-V control unit. Sequences Fetch/Decode/Execute/
//            Memory/Writeback and drives every datapath select and enable.
//            Unsupported opcodes park the FSM in a sticky TRAP state.
// Revision : 1.0 - initial release
// ============================================================================
module mc_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    // Opcodes understood by this controller
    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    state_t     state_q;
    state_t     state_d;

    // Raw per-state controls before branch resolution and reset gating
    logic       w_pc_update;
    logic       w_branch;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu_ctrl;
    logic [1:0] w_imm_src;

    // State register; reset lands in FETCH immediately, mid-cycle if need be
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    c_OP_LW,
                    c_OP_SW:  state_d = S_MEMADR;
                    c_OP_R:   state_d = S_EXECR;
                    c_OP_I:   state_d = S_EXECI;
                    c_OP_BEQ: state_d = S_BEQ;
                    c_OP_JAL: state_d = S_JAL;
                    default:  state_d = S_TRAP;
                endcase
            end
            // Only lw and sw reach MEMADR; bit 5 separates store from load
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB,
            S_MEMWRITE,
            S_BEQ:      state_d = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_pc_update  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
            end
            S_DECODE: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b01;
            end
            S_MEMADR: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
            end
            S_MEMREAD: begin
                w_adr_src    = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_mem_write  = 1'b1;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
            end
            S_EXECR: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b00;
                w_alu_op     = 2'b10;
            end
            S_EXECI: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b01;
                w_alu_op     = 2'b10;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
            end
            S_BEQ: begin
                w_alu_src_a  = 2'b10;
                w_alu_src_b  = 2'b00;
                w_alu_op     = 2'b01;
                w_branch     = 1'b1;
            end
            S_JAL: begin
                w_alu_src_a  = 2'b01;
                w_alu_src_b  = 2'b10;
                w_pc_update  = 1'b1;
            end
            default: begin
                // TRAP and unused encodings keep every enable low
            end
        endcase
    end

    // ALU decoder: funct3 selects the operation for R/I-type execution
    always_comb begin
        w_alu_ctrl = 3'b000;
        case (w_alu_op)
            2'b00: w_alu_ctrl = 3'b000;
            2'b01: w_alu_ctrl = 3'b001;
            2'b10: begin
                case (funct3)
                    // Subtract only for R-type with funct7b5; addi never subtracts
                    3'b000:  w_alu_ctrl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  w_alu_ctrl = 3'b101;
                    3'b110:  w_alu_ctrl = 3'b011;
                    3'b111:  w_alu_ctrl = 3'b010;
                    default: w_alu_ctrl = 3'b000;
                endcase
            end
            default: w_alu_ctrl = 3'b000;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        w_imm_src = 2'b00;
        case (op)
            c_OP_SW:  w_imm_src = 2'b01;
            c_OP_BEQ: w_imm_src = 2'b10;
            c_OP_JAL: w_imm_src = 2'b11;
            default:  w_imm_src = 2'b00;
        endcase
    end

    // Enables are suppressed while reset is held; the state is already FETCH
    // then, so the selects naturally show their FETCH values.
    assign PCWrite    = ~rst & (w_pc_update | (w_branch & zero));
    assign IRWrite    = ~rst & w_ir_write;
    assign RegWrite   = ~rst & w_reg_write;
    assign MemWrite   = ~rst & w_mem_write;
    assign AdrSrc     = w_adr_src;
    assign ResultSrc  = w_result_src;
    assign ALUSrcA    = w_alu_src_a;
    assign ALUSrcB    = w_alu_src_b;
    assign ImmSrc     = w_imm_src;
    assign ALUControl = w_alu_ctrl;
    assign illegal    = (state_q == S_TRAP);
    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_controller
// Brief    : Self-checking bench for mc_controller. Directed instruction
//            words plus randomized instruction streams, compared each cycle
//            against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal;
    logic [3:0] state;

    int n_checks;
    int n_errors;

    // Instruction classes of the reference model
    localparam int c_LW  = 0;
    localparam int c_SW  = 1;
    localparam int c_R   = 2;
    localparam int c_I   = 3;
    localparam int c_JAL = 4;
    localparam int c_BEQ = 5;
    localparam int c_ILL = 6;

    mc_controller u_dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .illegal    (illegal),
        .state      (state)
    );

    // Packed view of every control output:
    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,illegal}
    logic [16:0] w_obs;
    assign w_obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int classify(input logic [6:0] o);
        case (o)
            7'b0000011: return c_LW;
            7'b0100011: return c_SW;
            7'b0110011: return c_R;
            7'b0010011: return c_I;
            7'b1101111: return c_JAL;
            7'b1100011: return c_BEQ;
            default:    return c_ILL;
        endcase
    endfunction

    // Cycles spent per instruction; an illegal one is observed for 14 cycles
    function automatic int instr_len(input int cls);
        case (cls)
            c_LW:    return 5;
            c_BEQ:   return 3;
            c_ILL:   return 14;
            default: return 4;
        endcase
    endfunction

    // ALU operation an R/I-type instruction asks for
    function automatic logic [2:0] alu_for(input int cls, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (cls == c_R && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Reference: expected state and controls at step k of an instruction
    task automatic model(input int cls, input int k, input logic [2:0] f3, input logic f7,
                         input logic z, output logic [3:0] st, output logic [16:0] ctl);
        logic       pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        rs = 0; sa = 0; sb = 0; alu = 0;
        imm = (cls == c_SW) ? 2'b01 : (cls == c_BEQ) ? 2'b10 : (cls == c_JAL) ? 2'b11 : 2'b00;
        st = 4'd0;
        if (k == 0) begin
            st = 4'd0; irw = 1; pcw = 1; sb = 2; rs = 2;
        end else if (k == 1) begin
            st = 4'd1; sa = 1; sb = 1;
        end else begin
            case (cls)
                c_LW, c_SW: begin
                    if (k == 2) begin st = 4'd2; sa = 2; sb = 1; end
                    else if (cls == c_SW) begin st = 4'd5; adr = 1; mw = 1; end
                    else if (k == 3) begin st = 4'd3; adr = 1; end
                    else begin st = 4'd4; rs = 1; rw = 1; end
                end
                c_R, c_I: begin
                    if (k == 2) begin
                        st = (cls == c_R) ? 4'd6 : 4'd7; sa = 2;
                        sb = (cls == c_R) ? 2'd0 : 2'd1;
                        alu = alu_for(cls, f3, f7);
                    end else begin st = 4'd8; rw = 1; end
                end
                c_JAL: begin
                    if (k == 2) begin st = 4'd10; sa = 1; sb = 2; pcw = 1; end
                    else begin st = 4'd8; rw = 1; end
                end
                c_BEQ: begin
                    st = 4'd9; sa = 2; sb = 0; alu = 3'b001; pcw = z;
                end
                default: begin st = 4'd15; ill = 1; end
            endcase
        end
        ctl = {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
    endtask

    // Expected outputs while reset is held: FETCH selects, enables low
    task automatic check_reset(input string tag);
        logic [3:0]  st;
        logic [16:0] ctl;
        model(classify(op), 0, funct3, funct7b5, 1'b0, st, ctl);
        ctl[16] = 1'b0;  // PCWrite
        ctl[13] = 1'b0;  // IRWrite
        check({tag, "_state"}, {28'd0, state}, {28'd0, st});
        check({tag, "_ctl"},   {15'd0, w_obs}, {15'd0, ctl});
    endtask

    // Called at posedge+1 of a FETCH cycle; returns at posedge+1 after max_steps
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int max_steps, input string tag);
        int          cls;
        int          len;
        logic [3:0]  st;
        logic [16:0] ctl;
        cls = classify(o);
        len = instr_len(cls);
        if (max_steps < len) len = max_steps;
        op = o; funct3 = f3; funct7b5 = f7;
        for (int k = 0; k < len; k++) begin
            zero = (cls == c_BEQ && k == 2) ? z : 1'($urandom);
            @(negedge clk);
            model(cls, k, f3, f7, zero, st, ctl);
            check($sformatf("%s_k%0d_state", tag, k), {28'd0, state}, {28'd0, st});
            check($sformatf("%s_k%0d_ctl", tag, k),   {15'd0, w_obs}, {15'd0, ctl});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_word(input logic [31:0] w, input logic z, input string tag);
        run_instr(w[6:0], w[14:12], w[30], z, 100, tag);
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        @(negedge clk);
        check_reset(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] o;
        logic [6:0] ops [6];
        int         cls;
        n_checks = 0;
        n_errors = 0;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1101111; ops[5] = 7'b1100011;

        rst = 1'b1; op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed instruction words
        run_word(32'h00600413, 1'b0, "addi");
        run_word(32'h409409B3, 1'b0, "sub");
        run_word(32'h00940933, 1'b0, "add");
        run_word(32'h0004A403, 1'b0, "lw");
        run_word(32'h0084A023, 1'b0, "sw");
        run_word(32'h00940463, 1'b1, "beq_taken");
        run_word(32'h00940463, 1'b0, "beq_not");
        run_word(32'h00000000, 1'b0, "trap");
        reset_pulse("trap_rst");
        run_word(32'h00600413, 1'b0, "after_trap");

        // Reset asserted asynchronously in the middle of a MEMWRITE cycle
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 3, "sw_cut");
        check("memwrite_before_rst", {28'd0, state}, 32'd5);
        check("mw_before_rst", {31'd0, MemWrite}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", {28'd0, state}, 32'd0);
        check("async_rst_mw", {31'd0, MemWrite}, 32'd0);
        check_reset("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_word(32'h0004A403, 1'b0, "after_async");

        // Randomized instruction stream, occasionally illegal
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do o = 7'($urandom); while (classify(o) != c_ILL);
            end else begin
                o = ops[$urandom_range(0, 5)];
            end
            cls = classify(o);
            run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), 100,
                      $sformatf("rnd%0d", i));
            if (cls == c_ILL) reset_pulse($sformatf("rnd%0d_rst", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
